// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   ldr_state_t  : loader sequencing states (IDLE -> LOAD -> RUN)
//   WORD_BYTES   : bytes per instruction word
//   RTYPE_OPCODE : R-type opcode, also used by the core's decoder
//   is_rtype()   : helper, true when a word carries the R-type opcode
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } ldr_state_t;

  localparam int WORD_BYTES = 4;

  localparam logic [6:0] RTYPE_OPCODE = 7'b0110011;

  // Anything that is not R-type (including an all-zero word) is a no-op for
  // the core, which is why cleared memory is safe to execute.
  function automatic logic is_rtype(input logic [31:0] word);
    return (word[6:0] == RTYPE_OPCODE);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Instruction-word stream into the loader (valid/ready handshake).
//   s_valid : word valid (source -> loader)
//   s_ready : loader can accept a word (loader -> source)
//   s_word  : 32-bit instruction word, little-endian packed into memory
//   s_last  : final word of the program, qualified by a transfer
// Modports: master = word source, slave = loader.
// -----------------------------------------------------------------------------
interface imem_loader_if;

  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_word;
  logic        s_last;

  modport master (
    output s_valid,
    output s_word,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_word,
    input  s_last,
    output s_ready
  );

endinterface

// File: rtl/imem_loader_byte_bank.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_bank
// DEPTH-byte storage that the core reads as its instruction memory.
// One 32-bit little-endian word write port at a byte address, plus a
// synchronous clear of the whole array.
//   clk, reset_n : clock, asynchronous active-low reset (clears all bytes)
//   i_clear      : clear every byte on this edge (wins over a write)
//   i_we         : write i_wdata at byte address i_addr
//   i_addr       : byte address of the least significant byte
//   i_wdata      : word; byte k goes to address i_addr+k
//   o_bytes      : the whole array, straight from the byte registers
// -----------------------------------------------------------------------------
module imem_loader_byte_bank
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clear,
  input  logic             i_we,
  input  logic [PTR_W-1:0] i_addr,
  input  logic [31:0]      i_wdata,
  output logic [7:0]       o_bytes [DEPTH]
);

  // The core reads every byte in parallel, so the storage is a bank of
  // individually addressed byte registers rather than a RAM macro.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_byte
    localparam logic [PTR_W-1:0] BYTE_ADDR = PTR_W'(gi);

    logic [PTR_W-1:0] w_off;
    logic             w_hit;
    logic [7:0]       w_lane;
    logic [7:0]       r_byte;

    // Distance of this byte above the write address; it is one of the
    // four written lanes when that distance is below WORD_BYTES.
    assign w_off  = BYTE_ADDR - i_addr;
    assign w_hit  = i_we && (w_off < PTR_W'(WORD_BYTES));
    assign w_lane = i_wdata[{w_off[1:0], 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_byte <= 8'h00;
      end else if (i_clear) begin
        r_byte <= 8'h00;
      end else if (w_hit) begin
        r_byte <= w_lane;
      end
    end

    assign o_bytes[gi] = r_byte;
  end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the single-cycle core's instruction memory. Accepts 32-bit
// words on a valid/ready stream, packs them little-endian into a byte array
// and sequences the core: held in reset while loading, released and clocked
// through its enable once the program is resident.
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_start        : 1-cycle pulse; clear memory and (re)load (ignored in LOAD)
//   s_if (slave)   : s_valid / s_ready / s_word / s_last word stream
//   o_imem         : DEPTH bytes to the core's instruction-memory input
//   o_core_reset   : active-high core reset, low only in RUN
//   o_core_en      : core evaluate enable, toggles every clock in RUN
//   o_load_done    : program resident and core running
//   o_trunc_err    : sticky, memory filled before s_last arrived
//   o_word_count   : words written in the current load
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_start,
  imem_loader_if.slave     s_if,
  output logic [7:0]       o_imem [DEPTH],
  output logic             o_core_reset,
  output logic             o_core_en,
  output logic             o_load_done,
  output logic             o_trunc_err,
  output logic [PTR_W-1:0] o_word_count
);

  localparam logic [PTR_W:0] DEPTH_X   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] WORD_STEP = (PTR_W + 1)'(WORD_BYTES);

  ldr_state_t       r_state;
  ldr_state_t       w_state_next;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_word_count;
  logic             r_trunc_err;
  logic             r_core_en;
  logic             w_core_en_next;

  logic [PTR_W:0]   w_ptr_sum;
  logic             w_s_ready;
  logic             w_xfer;
  logic             w_fill;
  logic             w_clear;

  // One extra bit so the sum can be compared with DEPTH even when DEPTH
  // equals 2**PTR_W.
  assign w_ptr_sum = {1'b0, r_wr_ptr} + WORD_STEP;
  assign w_s_ready = (r_state == LOAD) && ({1'b0, r_wr_ptr} < DEPTH_X);
  assign w_xfer    = s_if.s_valid && w_s_ready;
  assign w_fill    = w_xfer && (w_ptr_sum >= DEPTH_X);
  // A start is honoured from IDLE or RUN only; a start mid-load is dropped.
  assign w_clear   = i_start && (r_state != LOAD);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_core_en_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        // Filling the last word ends the load whether or not s_last came.
        if (w_xfer && (s_if.s_last || w_fill)) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (i_start) begin
          w_state_next = LOAD;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // The enable only toggles between two RUN cycles: it stays low on the
    // entry edge (so the first toggle lands one cycle into RUN) and drops
    // on the same edge that leaves RUN for a reload.
    if ((r_state == RUN) && (w_state_next == RUN)) begin
      w_core_en_next = ~r_core_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointer, counters and status
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_trunc_err  <= 1'b0;
      r_core_en    <= 1'b0;
    end else begin
      r_core_en <= w_core_en_next;
      if (w_clear) begin
        r_wr_ptr     <= '0;
        r_word_count <= '0;
        r_trunc_err  <= 1'b0;
      end else if (w_xfer) begin
        // The pointer never wraps; when DEPTH is 2**PTR_W the final
        // increment does not fit and the pointer simply holds.
        if (!w_ptr_sum[PTR_W]) begin
          r_wr_ptr <= w_ptr_sum[PTR_W-1:0];
        end
        r_word_count <= r_word_count + 1'b1;
        if (w_fill && !s_if.s_last) begin
          r_trunc_err <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory
  // ---------------------------------------------------------------------------
  imem_loader_byte_bank #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .i_we    (w_xfer),
    .i_addr  (r_wr_ptr),
    .i_wdata (s_if.s_word),
    .o_bytes (o_imem)
  );

  assign s_if.s_ready = w_s_ready;
  assign o_core_reset = (r_state != RUN);
  assign o_load_done  = (r_state == RUN);
  assign o_core_en    = r_core_en;
  assign o_trunc_err  = r_trunc_err;
  assign o_word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed bench for imem_loader with DEPTH=8. Inputs change 1 ns after the
// rising edge, outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int DEPTH = 8;
  localparam int PTR_W = 8;

  logic             clk;
  logic             reset_n;
  logic             i_start;
  logic [7:0]       o_imem [DEPTH];
  logic             o_core_reset;
  logic             o_core_en;
  logic             o_load_done;
  logic             o_trunc_err;
  logic [PTR_W-1:0] o_word_count;

  int n_cmp = 0;
  int n_mis = 0;

  imem_loader_if s_bus ();

  imem_loader #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_start      (i_start),
    .s_if         (s_bus.slave),
    .o_imem       (o_imem),
    .o_core_reset (o_core_reset),
    .o_core_en    (o_core_en),
    .o_load_done  (o_load_done),
    .o_trunc_err  (o_trunc_err),
    .o_word_count (o_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory as one 64-bit value, byte 7 in the top bits.
  function automatic logic [63:0] mem64();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v[8*i +: 8] = o_imem[i];
    return v;
  endfunction

  // status = {s_ready, core_reset, core_en, load_done, trunc_err}
  function automatic logic [63:0] status();
    return {59'd0, s_bus.s_ready, o_core_reset, o_core_en, o_load_done, o_trunc_err};
  endfunction

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic last);
    s_bus.s_valid = 1'b1;
    s_bus.s_word  = w;
    s_bus.s_last  = last;
    step();
    s_bus.s_valid = 1'b0;
    s_bus.s_last  = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic exp_en;
    reset_n       = 1'b0;
    i_start       = 1'b0;
    s_bus.s_valid = 1'b0;
    s_bus.s_word  = '0;
    s_bus.s_last  = 1'b0;
    step();
    step();
    $display("reset: status=%b wc=%0d", status(), o_word_count);
    chk("reset_status", status(), 64'b01000);
    chk("reset_wc", 64'(o_word_count), 64'd0);
    chk("reset_mem", mem64(), 64'h0);
    reset_n = 1'b1;
    step();
    chk("idle_status", status(), 64'b01000);

    // Two-word program: add x7,x5,x6 then sub x8,x5,x1.
    pulse_start();
    $display("start: status=%b", status());
    chk("load_status", status(), 64'b11000);
    send(32'h006283B3, 1'b0);
    $display("word0: mem=%h wc=%0d", mem64(), o_word_count);
    chk("word0_mem", mem64(), 64'h00000000_006283B3);
    chk("word0_wc", 64'(o_word_count), 64'd1);
    send(32'h40128433, 1'b1);
    $display("word1: mem=%h wc=%0d status=%b", mem64(), o_word_count, status());
    chk("prog_mem", mem64(), 64'h40128433_006283B3);
    chk("prog_wc", 64'(o_word_count), 64'd2);
    chk("run_entry_status", status(), 64'b00010);
    // core_en alternates every cycle in RUN, starting high one cycle in.
    exp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      $display("run cycle %0d: core_en=%b", i, o_core_en);
      chk("run_core_en", 64'(o_core_en), 64'(exp_en));
      chk("run_core_reset", 64'(o_core_reset), 64'd0);
      exp_en = ~exp_en;
    end

    // Reload from RUN, then async reset in the middle of the load.
    pulse_start();
    $display("reload: status=%b mem=%h", status(), mem64());
    chk("reload_status", status(), 64'b11000);
    chk("reload_clear", mem64(), 64'h0);
    send(32'h11223344, 1'b0);
    chk("midload_mem", mem64(), 64'h00000000_11223344);
    #1 reset_n = 1'b0;
    #2;
    $display("async reset: status=%b mem=%h wc=%0d", status(), mem64(), o_word_count);
    chk("async_status", status(), 64'b01000);
    chk("async_mem", mem64(), 64'h0);
    chk("async_wc", 64'(o_word_count), 64'd0);
    #1 reset_n = 1'b1;
    step();

    // Backpressure / truncation: three words, no s_last, gaps between.
    pulse_start();
    step();
    send(32'h03020100, 1'b0);
    chk("bp_wc1", 64'(o_word_count), 64'd1);
    step();
    send(32'h07060504, 1'b0);
    $display("fill: status=%b wc=%0d mem=%h", status(), o_word_count, mem64());
    chk("fill_status", status(), 64'b00011);
    chk("fill_wc", 64'(o_word_count), 64'd2);
    send(32'h0B0A0908, 1'b0);
    chk("reject_mem", mem64(), 64'h07060504_03020100);
    chk("reject_wc", 64'(o_word_count), 64'd2);

    // Single word with s_last: upper word stays cleared.
    pulse_start();
    chk("restart_trunc_clr", status(), 64'b11000);
    send(32'h006283B3, 1'b1);
    $display("single: mem=%h wc=%0d status=%b", mem64(), o_word_count, status());
    chk("single_mem", mem64(), 64'h00000000_006283B3);
    chk("single_wc", 64'(o_word_count), 64'd1);
    chk("single_status", status(), 64'b00010);

    // start during LOAD is ignored; stray s_last without valid does nothing.
    pulse_start();
    send(32'h11111111, 1'b0);
    pulse_start();
    $display("start in load: wc=%0d mem=%h status=%b", o_word_count, mem64(), status());
    chk("ign_start_wc", 64'(o_word_count), 64'd1);
    chk("ign_start_mem", mem64(), 64'h00000000_11111111);
    chk("ign_start_status", status(), 64'b11000);
    s_bus.s_last = 1'b1;
    step();
    s_bus.s_last = 1'b0;
    chk("stray_last_status", status(), 64'b11000);
    send(32'h22222222, 1'b1);
    step();
    chk("run_en_before_reload", 64'(o_core_en), 64'd1);
    pulse_start();
    $display("reload2: status=%b mem=%h", status(), mem64());
    chk("reload2_status", status(), 64'b11000);
    chk("reload2_clear", mem64(), 64'h0);
    send(32'h40128433, 1'b1);
    chk("reload2_mem", mem64(), 64'h00000000_40128433);
    chk("reload2_wc", 64'(o_word_count), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
